// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal-length tap table, request FSM encoding and
// the state helpers used by both the core register and the wrap detector.
package lfsr_pkg;

  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } fsm_t;

  // Bit i set means state bit i is XORed into the new LSB after the left shift.
  // Each entry realises a primitive polynomial x^W + ... + 1.
  function automatic logic [15:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      3:       m = 16'h0005; // x^3 + x^2 + 1
      4:       m = 16'h0009; // x^4 + x^3 + 1
      5:       m = 16'h0012; // x^5 + x^3 + 1
      6:       m = 16'h0021; // x^6 + x^5 + 1
      7:       m = 16'h0041; // x^7 + x^6 + 1
      8:       m = 16'h008E; // x^8 + x^6 + x^5 + x^4 + 1
      9:       m = 16'h0108; // x^9 + x^5 + 1
      10:      m = 16'h0204; // x^10 + x^7 + 1
      11:      m = 16'h0402; // x^11 + x^9 + 1
      12:      m = 16'h0CA0; // x^12 + x^6 + x^4 + x + 1
      13:      m = 16'h1B00; // x^13 + x^4 + x^3 + x + 1
      14:      m = 16'h3500; // x^14 + x^5 + x^3 + x + 1
      15:      m = 16'h4001; // x^15 + x^14 + 1
      16:      m = 16'h8805; // x^16 + x^15 + x^13 + x^4 + 1
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // The all-zero state is a lockup point for an XOR LFSR, so it maps to 1.
  function automatic logic [15:0] nz(input logic [15:0] x);
    return (x == 16'd0) ? 16'd1 : x;
  endfunction

  // One Fibonacci step of a w-bit register held in the low bits of s.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input int w);
    logic [16:0] lim;
    logic        fb;
    lim = (17'd1 << w) - 17'd1;
    fb  = ^(s & tap_mask(w));
    return {s[14:0], fb} & lim[15:0];
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: reset to the zero-guarded SEED, runtime reseed, and a
// single Fibonacci step per enabled cycle.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(nz(16'(SEED)));

  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_core: WIDTH must be in 3..16");
  end

  // Reset beats load, load beats step; a load cycle never also steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
    end else if (load) begin
      state <= WIDTH'(nz(16'(seed_in)));
    end else if (en) begin
      state <= WIDTH'(lfsr_next(16'(state), WIDTH));
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random source with a rejection-sampled bounded output in [0, OUT_MAX]
// and a pulse marking each return to the start value.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int SEED    = 1,
  parameter int OUT_MAX = 47
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] START_RST = WIDTH'(nz(16'(SEED)));
  localparam logic [WIDTH-1:0] BOUND     = WIDTH'(OUT_MAX);

  if (OUT_MAX < 1 || OUT_MAX > (1 << WIDTH) - 2) begin : g_bad_bound
    $error("lfsr_rng: OUT_MAX must be in 1..2^WIDTH-2");
  end

  fsm_t             fsm;
  fsm_t             fsm_nxt;
  logic             step;
  logic             accept;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] state_nxt;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (step),
    .load    (load),
    .seed_in (seed_in),
    .state   (number)
  );

  // A search consumes one state per cycle; en adds no extra step on top.
  assign busy      = (fsm == SEARCH);
  assign step      = en | busy;
  assign state_nxt = WIDTH'(lfsr_next(16'(number), WIDTH));

  // Requests are only taken in IDLE; a load cycle re-seeds instead of
  // consuming the current state, so the search resumes from the new seed.
  always_comb begin
    fsm_nxt = fsm;
    accept  = 1'b0;
    case (fsm)
      IDLE: begin
        if (req) fsm_nxt = SEARCH;
      end
      SEARCH: begin
        if (!load && (number <= BOUND)) begin
          accept  = 1'b1;
          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // Start value of the current period, re-anchored by every load.
  always_ff @(posedge clk) begin
    if (reset)     start <= START_RST;
    else if (load) start <= WIDTH'(nz(16'(seed_in)));
  end

  // Accepted value is captured with a one-cycle valid and held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnd       <= '0;
      rnd_valid <= 1'b0;
    end else begin
      rnd_valid <= accept;
      if (accept) rnd <= number;
    end
  end

  // Wrap flags a real step landing on the start value, never a load.
  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= step && !load && (state_nxt == start);
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: table-driven stepping/priority vectors, a scoreboard of
// expected bounded values, and period sweeps at widths 3, 6 and 16.
module tb_lfsr_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst6, en6, load6, req6;
  logic [5:0] seed6, num6, rnd6;
  logic       val6, busy6, wrap6;

  logic       rst3, en3, load3, req3;
  logic [2:0] seed3, num3, rnd3;
  logic       val3, busy3, wrap3;

  logic        rst16, en16, load16, req16;
  logic [15:0] seed16, num16, rnd16;
  logic        val16, busy16, wrap16;

  lfsr_rng #(.WIDTH(6), .SEED(1), .OUT_MAX(47)) dut6 (
    .clk(clk), .reset(rst6), .en(en6), .load(load6), .seed_in(seed6), .req(req6),
    .number(num6), .rnd(rnd6), .rnd_valid(val6), .busy(busy6), .wrap(wrap6));

  lfsr_rng #(.WIDTH(3), .SEED(1), .OUT_MAX(1)) dut3 (
    .clk(clk), .reset(rst3), .en(en3), .load(load3), .seed_in(seed3), .req(req3),
    .number(num3), .rnd(rnd3), .rnd_valid(val3), .busy(busy3), .wrap(wrap3));

  lfsr_rng #(.WIDTH(16), .SEED(1), .OUT_MAX(47)) dut16 (
    .clk(clk), .reset(rst16), .en(en16), .load(load16), .seed_in(seed16), .req(req16),
    .number(num16), .rnd(rnd16), .rnd_valid(val16), .busy(busy16), .wrap(wrap16));

  typedef struct {
    logic       rst, en, load;
    logic [5:0] seed;
    logic [5:0] num, rnd;
    logic       busy, wrap;
  } vec_t;

  typedef struct {
    int val;
    int due;
    int reqc;
  } exp_t;

  exp_t q6[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   max_lat3 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic l,
                              input logic [5:0] sd, input logic [5:0] n);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.seed = sd; v.num = n;
    v.rnd = 6'h00; v.busy = 1'b0; v.wrap = 1'b0;
    return v;
  endfunction

  // Reference step for x^3 + x^2 + 1: new LSB = bit2 ^ bit0 after a left shift.
  function automatic int model3_next(input int s);
    int fb;
    fb = ((s >> 2) & 1) ^ (s & 1);
    return ((s << 1) | fb) & 7;
  endfunction

  // One clock; sample 1 time unit after the edge and serve both scoreboards.
  task automatic tick();
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    cyc++;
    if (val6 === 1'b1) begin
      if (q6.size() == 0) check("rnd6_spurious", 32'(val6), 0);
      else begin
        e = q6.pop_front();
        check("rnd6_value", 32'(rnd6), e.val);
        check("rnd6_latency", cyc, e.due);
      end
    end else if (q6.size() != 0 && cyc >= q6[0].due) begin
      e = q6.pop_front();
      check("rnd6_missing", 32'(val6), 1);
    end
    if (val3 === 1'b1) begin
      if (q3.size() == 0) check("rnd3_spurious", 32'(val3), 0);
      else begin
        e = q3.pop_front();
        check("rnd3_value", 32'(rnd3), e.val);
        check("rnd3_range", 32'(rnd3 <= 3'd1), 1);
        check("rnd3_latency", cyc, e.due);
        lat = cyc - e.reqc;
        if (lat > max_lat3) max_lat3 = lat;
      end
    end else if (q3.size() != 0 && cyc >= q3[0].due) begin
      e = q3.pop_front();
      check("rnd3_missing", 32'(val3), 1);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL timeout actual=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[16];
    bit   seen6[64];
    int   n, ret, zero, wr, wrat, distinct, w1, w2, s, k, m3, nst;

    rst6 = 1'b1; en6 = 1'b0; load6 = 1'b0; req6 = 1'b0; seed6 = '0;
    rst3 = 1'b1; en3 = 1'b0; load3 = 1'b0; req3 = 1'b0; seed3 = '0;
    rst16 = 1'b1; en16 = 1'b0; load16 = 1'b0; req16 = 1'b0; seed16 = '0;
    tick();

    // Stepping sequence, zero-seed guard and load-over-step priority.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 6'h00, 6'h01);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h03);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h07);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h0F);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h1F);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h3F);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h3E);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h3D);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h3A);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h35);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h2A);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 6'h00, 6'h01);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 6'h00, 6'h03);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 6'h3F, 6'h3F);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 6'h00, 6'h3F);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 6'h2A, 6'h2A);
    for (int i = 0; i < 16; i++) begin
      rst6 = tbl[i].rst; en6 = tbl[i].en; load6 = tbl[i].load; seed6 = tbl[i].seed;
      tick();
      check($sformatf("vec%0d_number", i), 32'(num6), 32'(tbl[i].num));
      check($sformatf("vec%0d_rnd", i), 32'(rnd6), 32'(tbl[i].rnd));
      check($sformatf("vec%0d_busy", i), 32'(busy6), 32'(tbl[i].busy));
      check($sformatf("vec%0d_wrap", i), 32'(wrap6), 32'(tbl[i].wrap));
    end
    load6 = 1'b0;

    // Full period from reset: coverage, wrap placement, no wrap on load.
    rst6 = 1'b1; en6 = 1'b0; tick(); rst6 = 1'b0; en6 = 1'b1;
    distinct = 0; zero = 0; wr = 0; w1 = 0; w2 = 0;
    for (int i = 0; i < 64; i++) seen6[i] = 1'b0;
    for (int i = 1; i <= 188; i++) begin
      tick();
      if (i <= 63 && !seen6[num6]) begin seen6[num6] = 1'b1; distinct++; end
      if (num6 == 6'd0) zero++;
      if (wrap6) begin
        wr++;
        if (wr == 1) w1 = i;
        else if (wr == 2) w2 = i;
      end
    end
    check("p6_distinct", distinct, 63);
    check("p6_zero", zero, 0);
    check("p6_wrap_count", wr, 2);
    check("p6_wrap_first", w1, 63);
    check("p6_wrap_second", w2, 126);
    // State 0x20 steps into the start value 1; a load here must not wrap.
    check("p6_pre_start", 32'(num6), 'h20);
    load6 = 1'b1; seed6 = 6'h01; tick(); load6 = 1'b0;
    check("p6_load_nowrap", 32'(wrap6), 0);
    check("p6_load_num", 32'(num6), 'h01);
    tick();
    check("p6_after_load", 32'(num6), 'h03);
    en6 = 1'b0;

    // Rejection walk 3F,3E,3D,3A,35 then accept 2A; req while busy ignored.
    load6 = 1'b1; seed6 = 6'h3F; tick(); load6 = 1'b0;
    req6 = 1'b1; n = cyc; q6.push_back('{42, n + 7, n}); tick(); req6 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("rej_busy_%0d", i), 32'(busy6), 1);
      req6 = (i == 3);
      tick();
    end
    req6 = 1'b0;
    check("rej_busy_end", 32'(busy6), 0);
    repeat (4) tick();
    check("rej_rnd_hold", 32'(rnd6), 42);
    check("rej_num_stepped", 32'(num6), 'h15);
    check("rej_idle", 32'(busy6), 0);

    // req together with load, en held high through the search.
    en6 = 1'b1; load6 = 1'b1; seed6 = 6'h3F; req6 = 1'b1;
    n = cyc; q6.push_back('{42, n + 7, n}); tick();
    load6 = 1'b0; req6 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("rl_busy_%0d", i), 32'(busy6), 1);
      tick();
    end
    check("rl_busy_end", 32'(busy6), 0);
    check("rl_num", 32'(num6), 'h15);
    en6 = 1'b0;

    // Load mid-search restarts the walk from the new seed.
    load6 = 1'b1; seed6 = 6'h3F; req6 = 1'b1;
    n = cyc; q6.push_back('{42, n + 10, n}); tick();
    load6 = 1'b0; req6 = 1'b0;
    tick(); tick();
    load6 = 1'b1; tick(); load6 = 1'b0;
    check("ls_reloaded", 32'(num6), 'h3F);
    check("ls_busy", 32'(busy6), 1);
    repeat (6) tick();
    check("ls_busy_end", 32'(busy6), 0);

    // Reset two cycles into a search: no result, back to reset state.
    load6 = 1'b1; seed6 = 6'h3F; tick(); load6 = 1'b0;
    req6 = 1'b1; tick();
    tick();
    req6 = 1'b0; rst6 = 1'b1; tick(); rst6 = 1'b0;
    check("rs_busy", 32'(busy6), 0);
    check("rs_valid", 32'(val6), 0);
    check("rs_num", 32'(num6), 'h01);
    check("rs_rnd", 32'(rnd6), 0);
    repeat (10) tick();
    check("rs_num_hold", 32'(num6), 'h01);
    check("rs_busy_hold", 32'(busy6), 0);

    // Width 3: period 7 and bounded requests with OUT_MAX=1.
    rst3 = 1'b0; en3 = 1'b1;
    ret = 0; zero = 0; wr = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (num3 == 3'd0) zero++;
      if (wrap3) wr++;
      if (num3 == 3'd1 && ret == 0) ret = i;
    end
    en3 = 1'b0;
    check("p3_period", ret, 7);
    check("p3_zero", zero, 0);
    check("p3_wrap_count", wr, 2);
    m3 = 1;
    for (int i = 1; i <= 14; i++) m3 = model3_next(m3);
    for (int r = 0; r < 100; r++) begin
      check("w3_number", 32'(num3), m3);
      s = m3; k = 0;
      while (s > 1) begin s = model3_next(s); k++; end
      req3 = 1'b1; n = cyc; q3.push_back('{s, n + k + 2, n}); tick(); req3 = 1'b0;
      m3 = model3_next(s);
      for (int t = 0; t < 12 && busy3; t++) tick();
      check("w3_done", 32'(busy3), 0);
      nst = $urandom_range(0, 3);
      en3 = 1'b1;
      for (int t = 0; t < nst; t++) begin tick(); m3 = model3_next(m3); end
      en3 = 1'b0;
    end
    tick(); tick();
    // Only state 1 is acceptable, so up to six of the seven states are rejected.
    check("w3_max_latency", 32'(max_lat3 <= 8), 1);

    // Width 16: full period 65535 without touching zero.
    rst16 = 1'b0; en16 = 1'b1;
    ret = 0; zero = 0; wr = 0; wrat = 0;
    for (int i = 1; i <= 70000 && ret == 0; i++) begin
      tick();
      if (num16 == 16'd0) zero++;
      if (wrap16) begin wr++; wrat = i; end
      if (num16 == 16'h0001) ret = i;
    end
    en16 = 1'b0;
    check("p16_period", ret, 65535);
    check("p16_zero", zero, 0);
    check("p16_wrap_count", wr, 1);
    check("p16_wrap_at", wrat, 65535);

    check("q6_drained", q6.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
